display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 18 +
 rtl/display_scan_ctrl_if.sv | 25 ++
 rtl/hex_to_7seg.sv | 30 +++
 rtl/display_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
package display_pkg;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Phase within one digit slot: anodes off (anti-ghosting), then the digit lit.
  typedef enum logic {
    PhBlank,
    PhOn
  } phase_e;

  // Width of the slot counter for a given prescale.
  function automatic int unsigned cnt_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Application-side bus of the scan controller: value write port and status.
interface display_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  wr_en;
  logic                  lzs_en;
  logic                  pending;
  logic                  frame_start;

  // Application side.
  modport master (
    output value, dp_in, wr_en, lzs_en,
    input  pending, frame_start
  );

  // Scan controller side.
  modport slave (
    input  value, dp_in, wr_en, lzs_en,
    output pending, frame_start
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Combinational decode table.
  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// One shared decoder, blanking at each slot start, and a double-buffered value that
// only changes at a frame boundary.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned PRESCALE     = 12000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scan_ctrl_if.slave    bus,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int unsigned CntW = cnt_width(PRESCALE);
  localparam int unsigned DigW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CntW-1:0] CntMax       = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [DigW-1:0] DigMax       = DigW'(N_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DigW-1:0]       dig_q, dig_d;
  phase_e                phase_q, phase_d;
  logic [4*N_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic                  lzs_q, lzs_d;
  logic                  frame_start_q, frame_start_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [N_DIGITS-1:0]   lead_zero;
  logic                  upper_zero;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_sup;
  logic [N_DIGITS-1:0]   an_on;
  logic [6:0]            dec_seg;

  // Slot counter and digit index advance.
  always_comb begin
    slot_end  = (cnt_q == CntMax);
    frame_end = slot_end && (dig_q == DigMax);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    dig_d     = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == DigMax) ? '0 : dig_q + 1'b1;
    end
  end

  // Slot phase: blank for the first BLANK_CYCLES counts, lit for the rest.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PhBlank: if (cnt_q == CntBlankLast) phase_d = PhOn;
      PhOn:    if (slot_end) phase_d = PhBlank;
    endcase
  end

  // Double buffer: writes land in the pending buffer unless they hit the boundary cycle.
  always_comb begin
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;
    if (frame_end && pending_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pending_d  = 1'b0;
    end
    if (bus.wr_en) begin
      if (frame_end) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
        pending_d  = 1'b0;
      end else begin
        pend_val_d = bus.value;
        pend_dp_d  = bus.dp_in;
        pending_d  = 1'b1;
      end
    end
    // Suppression mode is latched once per slot so a digit never changes mid-slot.
    lzs_d         = (cnt_q == '0) ? bus.lzs_en : lzs_q;
    frame_start_d = frame_end;
  end

  // lead_zero[d]: nibbles N_DIGITS-1 down to d are all zero.
  always_comb begin
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      upper_zero   = upper_zero && (disp_val_q[4*d +: 4] == 4'h0);
      lead_zero[d] = upper_zero;
    end
  end

  // Select the nibble, decimal point and anode of the current digit.
  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_sup = 1'b0;
    an_on   = '1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (dig_q == DigW'(d)) begin
        sel_nib  = disp_val_q[4*d +: 4];
        sel_dp   = disp_dp_q[d];
        sel_sup  = (d != 0) && lead_zero[d];
        an_on[d] = 1'b0;
      end
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .hex_i (sel_nib),
    .seg_o (dec_seg)
  );

  // Next pin values; anode and pattern switch together on the same edge.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (phase_q == PhOn) begin
      an_d  = an_on;
      dp_d  = ~sel_dp;
      seg_d = (lzs_q && sel_sup) ? SEG_OFF : dec_seg;
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      dig_q         <= '0;
      phase_q       <= PhBlank;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pending_q     <= 1'b0;
      lzs_q         <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      phase_q       <= phase_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pending_q     <= pending_d;
      lzs_q         <= lzs_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;
  assign seg             = seg_q;
  assign dp              = dp_q;
  assign an              = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (N_DIGITS=4, PRESCALE=10, BLANK_CYCLES=2).
module tb_display_scan_ctrl;

  localparam int ND     = 4;
  localparam int PRE    = 10;
  localparam int BLANK  = 2;
  localparam int ON_LEN = PRE - BLANK;

  typedef struct {
    int         start;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  rec_t       sb_q[$];

  display_scan_ctrl_if #(.N_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .N_DIGITS     (ND),
    .PRESCALE     (PRE),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .seg (seg),
    .dp  (dp),
    .an  (an)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write(input int at, input logic [15:0] v, input logic [3:0] d);
    wait_cyc(at);
    bus.value  = v;
    bus.dp_in  = d;
    bus.wr_en  = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en  = 1'b0;
  endtask

  // segs packed {d3,d2,d1,d0}; dpv is dp_in (1 = lit, so pin is low).
  task automatic push_frame(input int f, input logic [27:0] segs, input logic [3:0] dpv);
    rec_t r;
    for (int d = 0; d < ND; d++) begin
      r.start = 40 * f + 10 * d + BLANK + 1;
      r.an    = 4'b1111;
      r.an[d] = 1'b0;
      r.seg   = segs[7*d +: 7];
      r.dp    = ~dpv[d];
      sb_q.push_back(r);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d slots never appeared, expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Monitor: on each lit slot pop the expected record; also check blank/lit run shape.
  bit         in_on;
  bit         seen_on;
  bit         blank_ok;
  bit         run_ok;
  int         on_len;
  int         blank_len;
  logic [3:0] c_an;
  logic [6:0] c_seg;
  logic       c_dp;

  initial begin : monitor
    rec_t r;
    in_on = 0; seen_on = 0; blank_ok = 1; run_ok = 1; on_len = 0; blank_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_on = 0; seen_on = 0; blank_ok = 1; blank_len = 0;
      end else if (an == 4'b1111) begin
        if (in_on) begin
          checks++;
          if (on_len != ON_LEN || !run_ok) begin
            errors++;
            $display("FAIL on_run an=%b: got len %0d stable %0d expected len %0d stable 1",
                     c_an, on_len, run_ok, ON_LEN);
          end
          in_on = 0; seen_on = 1; blank_len = 0; blank_ok = 1;
        end
        blank_len++;
        if (seg != 7'h7F || dp != 1'b1) blank_ok = 0;
      end else if (!in_on) begin
        checks++;
        if (!blank_ok || (seen_on && blank_len != BLANK)) begin
          errors++;
          $display("FAIL blank_run @cyc %0d: got len %0d clean %0d expected len %0d clean 1",
                   cyc, blank_len, blank_ok, BLANK);
        end
        if (sb_q.size() != 0) begin
          r = sb_q.pop_front();
          checks++;
          if (cyc != r.start || an != r.an || seg != r.seg || dp != r.dp) begin
            errors++;
            $display("FAIL slot: got cyc %0d an %b seg %b dp %b expected cyc %0d an %b seg %b dp %b",
                     cyc, an, seg, dp, r.start, r.an, r.seg, r.dp);
          end
        end
        in_on = 1; on_len = 1; run_ok = 1; c_an = an; c_seg = seg; c_dp = dp;
      end else begin
        on_len++;
        if (an != c_an || seg != c_seg || dp != c_dp) run_ok = 0;
      end
    end
  end

  localparam logic [27:0] Zeros = {7'h40, 7'h40, 7'h40, 7'h40};

  initial begin : stimulus
    bus.value  = 16'h1234;
    bus.dp_in  = 4'h0;
    bus.wr_en  = 1'b0;
    bus.lzs_en = 1'b0;

    // 1: reset state, scan order, frame_start timing.
    do_reset();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_pending", bus.pending, 0);
    push_frame(0, Zeros, 4'h0);
    push_frame(1, Zeros, 4'h0);
    wait_cyc(39); chk("frame_start_39", bus.frame_start, 0);
    wait_cyc(40); chk("frame_start_40", bus.frame_start, 1);
    wait_cyc(41); chk("frame_start_41", bus.frame_start, 0);
    wait_cyc(80); chk("frame_start_80", bus.frame_start, 1);
    drain();

    // 2: write applied at the frame boundary.
    do_reset();
    push_frame(0, Zeros, 4'h0);
    push_frame(1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'h0);
    wait_cyc(5); chk("pending_5", bus.pending, 0);
    write(5, 16'h1234, 4'h0);
    chk("pending_6", bus.pending, 1);
    wait_cyc(39); chk("pending_39", bus.pending, 1);
    wait_cyc(41); chk("pending_41", bus.pending, 0);
    drain();

    // 3: overwrite (last write wins) and a write in the boundary cycle.
    do_reset();
    push_frame(0, Zeros, 4'h0);
    push_frame(1, {7'h03, 7'h03, 7'h03, 7'h03}, 4'h0);
    push_frame(2, {7'h12, 7'h02, 7'h78, 7'h00}, 4'h0);
    write(5, 16'hAAAA, 4'h0);
    write(20, 16'hBBBB, 4'h0);
    chk("pending_21", bus.pending, 1);
    wait_cyc(79); chk("pending_79", bus.pending, 0);
    write(79, 16'h5678, 4'h0);
    chk("pending_80", bus.pending, 0);
    wait_cyc(81); chk("pending_81", bus.pending, 0);
    drain();

    // 4: leading-zero suppression on, then off.
    bus.lzs_en = 1'b1;
    do_reset();
    push_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h0);
    push_frame(1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'h0);
    push_frame(2, {7'h40, 7'h40, 7'h78, 7'h40}, 4'h0);
    write(5, 16'h0070, 4'h0);
    wait_cyc(78);
    bus.lzs_en = 1'b0;
    drain();

    // 5: decimal point, then reset in the middle of a lit slot.
    do_reset();
    push_frame(0, Zeros, 4'h0);
    push_frame(1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100);
    sb_q.push_back('{83, 4'b1110, 7'h19, 1'b1});
    sb_q.push_back('{93, 4'b1101, 7'h30, 1'b1});
    write(5, 16'h1234, 4'b0100);
    write(85, 16'h9999, 4'h0);
    wait_cyc(95);
    chk("pending_95", bus.pending, 1);
    chk("queue_95", sb_q.size(), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1);
    chk("midrst_pending", bus.pending, 0);
    rst = 1'b0;
    sb_q.delete();
    // Reset cleared both buffers: restart at digit 0 showing zeros.
    push_frame(0, Zeros, 4'h0);
    push_frame(1, Zeros, 4'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
